// File: rtl/aq_sys_cnt_gen_if.sv
// Load handshake bundle for the system counter generator.
// The master offers a load value, and the counter (slave) accepts it with ld_rdy.
interface aq_sys_cnt_gen_if #(
    parameter int CNT_W = 64
);
    logic             ld_vld;
    logic [CNT_W-1:0] ld_data;
    logic             ld_rdy;

    modport master (output ld_vld, output ld_data, input ld_rdy);
    modport slave  (input ld_vld, input ld_data, output ld_rdy);
endinterface

// File: rtl/aq_sys_cnt_gen.sv
// System counter generator: prescaled 64-bit up-counter with debug freeze,
// handshaked software load and a registered snapshot published on axim_clk_en.
module aq_sys_cnt_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 64
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  axim_clk_en,
    input  logic                  cnt_en,
    input  logic                  dbg_halt,
    input  logic [DIV_W-1:0]      cfg_div,
    aq_sys_cnt_gen_if.slave       ld,
    output logic [CNT_W-1:0]      pad_cpu_sys_cnt,
    output logic                  sys_cnt_wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e             st_q, st_d;
    logic [DIV_W-1:0]   pre_q, pre_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   pub_q, pub_d;
    logic               wrap_q, wrap_d;
    logic               rdy_q, rdy_d;
    logic               xfer;
    logic               tick;

    assign xfer = ld.ld_vld & rdy_q;
    // >= rather than == so lowering cfg_div below the running prescale ticks at once.
    assign tick = (st_q == ST_RUN) && (pre_q >= cfg_div);

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        st_d   = ST_IDLE;
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        rdy_d  = 1'b1;
        pub_d  = axim_clk_en ? cnt_q : pub_q;

        if (dbg_halt) begin
            st_d = ST_HALT;
        end else if (cnt_en) begin
            st_d = ST_RUN;
        end

        if (xfer) begin
            // A load wins over a coincident tick and never signals a wrap.
            cnt_d = ld.ld_data;
            pre_d = '0;
            rdy_d = 1'b0;
        end else begin
            unique case (st_q)
                ST_IDLE: pre_d = '0;
                ST_RUN: begin
                    if (tick) begin
                        pre_d  = '0;
                        cnt_d  = cnt_q + CNT_W'(1);
                        wrap_d = &cnt_q;
                    end else begin
                        pre_d = pre_q + DIV_W'(1);
                    end
                end
                ST_HALT: pre_d = pre_q;
                default: pre_d = '0;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            st_q   <= ST_IDLE;
            pre_q  <= '0;
            cnt_q  <= '0;
            pub_q  <= '0;
            wrap_q <= 1'b0;
            rdy_q  <= 1'b1;
        end else begin
            st_q   <= st_d;
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            pub_q  <= pub_d;
            wrap_q <= wrap_d;
            rdy_q  <= rdy_d;
        end
    end

    assign pad_cpu_sys_cnt = pub_q;
    assign sys_cnt_wrap    = wrap_q;
    assign ld.ld_rdy       = rdy_q;

endmodule
